// File: rtl/b_syn_updown.sv
// Up/down modulo counter with enable prescaler, synchronous load and wrap/saturate end behaviour.
// Latency: c and co update one cycle after the deciding edge; tc is combinational from c and up.
// Backpressure: none; en gates both prescaler progress and count steps, ld pre-empts a step.
module b_syn_updown #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SAT      = 0
) (
    input  logic             clk,
    input  logic             re,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             co
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    P_MAX = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] c_q, c_d;
    logic [PW-1:0]    p_q, p_d;
    logic             co_q, co_d;

    always_comb begin
        c_d  = c_q;
        p_d  = p_q;
        co_d = 1'b0;
        if (ld) begin
            // Out-of-range load values clamp to the top of the range.
            c_d = (d > C_MAX) ? C_MAX : d;
            p_d = '0;
        end else if (en) begin
            if (p_q != P_MAX) begin
                p_d = p_q + 1'b1;
            end else begin
                p_d = '0;
                if (up) begin
                    if (c_q != C_MAX) begin
                        c_d = c_q + 1'b1;
                    end else if (SAT == 0) begin
                        c_d  = '0;
                        co_d = 1'b1;
                    end
                end else begin
                    if (c_q != '0) begin
                        c_d = c_q - 1'b1;
                    end else if (SAT == 0) begin
                        c_d  = C_MAX;
                        co_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            c_q  <= '0;
            p_q  <= '0;
            co_q <= 1'b0;
        end else begin
            c_q  <= c_d;
            p_q  <= p_d;
            co_q <= co_d;
        end
    end

    assign c  = c_q;
    assign co = co_q;
    assign tc = up ? (c_q == C_MAX) : (c_q == '0);

endmodule

// File: tb/tb_b_syn_updown.sv
// Bench for b_syn_updown: four parameterisations share one stimulus stream and are
// compared against a per-instance arithmetic model of the counting rules.
module tb_b_syn_updown;

    logic       clk = 1'b0;
    logic       re, en, up, ld;
    logic [3:0] d;
    logic [3:0] c_o [4];
    logic [3:0] tc_o, co_o;

    int errors = 0;
    int checks = 0;

    // Instance 0: wrap M=10; 1: saturate M=10; 2: prescale 3, M=10; 3: wrap M=2
    int m_mod [4] = '{10, 10, 10, 2};
    int m_pre [4] = '{1, 1, 3, 1};
    int m_sat [4] = '{0, 1, 0, 0};
    int mc [4];
    int mp [4];
    bit mco [4];

    always #5 clk = ~clk;

    b_syn_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SAT(0)) u_wrap (
        .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
        .c(c_o[0]), .tc(tc_o[0]), .co(co_o[0]));
    b_syn_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SAT(1)) u_sat (
        .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
        .c(c_o[1]), .tc(tc_o[1]), .co(co_o[1]));
    b_syn_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SAT(0)) u_pre (
        .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
        .c(c_o[2]), .tc(tc_o[2]), .co(co_o[2]));
    b_syn_updown #(.WIDTH(4), .MODULUS(2), .PRESCALE(1), .SAT(0)) u_m2 (
        .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
        .c(c_o[3]), .tc(tc_o[3]), .co(co_o[3]));

    // One rising edge; the model counts enabled cycles and steps with modular arithmetic.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            int nxt;
            if (re) begin
                mc[i] = 0; mp[i] = 0; mco[i] = 1'b0;
            end else if (ld) begin
                mc[i] = (int'(d) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(d);
                mp[i] = 0; mco[i] = 1'b0;
            end else if (en) begin
                mco[i] = 1'b0;
                mp[i]++;
                if (mp[i] == m_pre[i]) begin
                    mp[i] = 0;
                    nxt = up ? mc[i] + 1 : mc[i] - 1;
                    if (nxt < 0 || nxt >= m_mod[i]) begin
                        if (m_sat[i] == 0) begin
                            mc[i]  = (nxt + m_mod[i]) % m_mod[i];
                            mco[i] = 1'b1;
                        end
                    end else begin
                        mc[i] = nxt;
                    end
                end
            end else begin
                mco[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        re = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; d = 4'd0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_o[i] !== 4'd0) begin errors++; $display("FAIL reset_c[%0d]: got %0d want 0", i, c_o[i]); end
            checks++;
            if (co_o[i] !== 1'b0) begin errors++; $display("FAIL reset_co[%0d]: got %b want 0", i, co_o[i]); end
            checks++;
            if (tc_o[i] !== 1'b1) begin errors++; $display("FAIL reset_tc_down[%0d]: got %b want 1", i, tc_o[i]); end
        end
        re = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (c_o[0] !== 4'(k % 10)) begin errors++; $display("FAIL up_c step %0d: got %0d want %0d", k, c_o[0], k % 10); end
            checks++;
            if (co_o[0] !== (k == 10)) begin errors++; $display("FAIL up_co step %0d: got %b want %b", k, co_o[0], k == 10); end
            checks++;
            if (tc_o[0] !== (k % 10 == 9)) begin errors++; $display("FAIL up_tc step %0d: got %b want %b", k, tc_o[0], k % 10 == 9); end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (c_o[i] !== 4'(mc[i]) || co_o[i] !== mco[i]) begin
                    errors++; $display("FAIL up_model[%0d]: got c=%0d co=%b want c=%0d co=%b", i, c_o[i], co_o[i], mc[i], mco[i]);
                end
            end
        end
    endtask

    task automatic test_load_down();
        ld = 1'b1; d = 4'd7; en = 1'b0;
        tick();
        ld = 1'b0;
        checks++;
        if (c_o[0] !== 4'd7) begin errors++; $display("FAIL load7: got %0d want 7", c_o[0]); end
        en = 1'b1; up = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            checks++;
            if (c_o[0] !== 4'((17 - j) % 10)) begin errors++; $display("FAIL down_c step %0d: got %0d want %0d", j, c_o[0], (17 - j) % 10); end
            checks++;
            if (co_o[0] !== (j == 8)) begin errors++; $display("FAIL down_co step %0d: got %b want %b", j, co_o[0], j == 8); end
            checks++;
            if (tc_o[0] !== (j == 7)) begin errors++; $display("FAIL down_tc step %0d: got %b want %b", j, tc_o[0], j == 7); end
        end
    endtask

    task automatic test_saturate();
        int exp_s [6] = '{8, 9, 9, 9, 8, 7};
        ld = 1'b1; d = 4'd8; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) ld = 1'b0;
            if (k == 4) up = 1'b0;
            tick();
            checks++;
            if (c_o[1] !== 4'(exp_s[k])) begin errors++; $display("FAIL sat_c %0d: got %0d want %0d", k, c_o[1], exp_s[k]); end
            checks++;
            if (co_o[1] !== 1'b0) begin errors++; $display("FAIL sat_co %0d: got %b want 0", k, co_o[1]); end
        end
    endtask

    task automatic test_prescale();
        bit tre [14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        bit ten [14] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        int tex [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 0, 0, 0, 1};
        up = 1'b1; ld = 1'b0;
        for (int k = 0; k < 14; k++) begin
            re = tre[k]; en = ten[k];
            tick();
            checks++;
            if (c_o[2] !== 4'(tex[k])) begin errors++; $display("FAIL prescale_c %0d: got %0d want %0d", k, c_o[2], tex[k]); end
        end
        re = 1'b0;
    endtask

    task automatic test_load_priority();
        ld = 1'b1; d = 4'd15; en = 1'b0; up = 1'b1;
        tick();
        checks++;
        if (c_o[0] !== 4'd9) begin errors++; $display("FAIL clamp_m10: got %0d want 9", c_o[0]); end
        checks++;
        if (c_o[3] !== 4'd1) begin errors++; $display("FAIL clamp_m2: got %0d want 1", c_o[3]); end
        d = 4'd3; en = 1'b1;
        tick();
        checks++;
        if (c_o[0] !== 4'd3) begin errors++; $display("FAIL ld_over_en: got %0d want 3", c_o[0]); end
        checks++;
        if (co_o[0] !== 1'b0) begin errors++; $display("FAIL ld_co: got %b want 0", co_o[0]); end
        re = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (c_o[i] !== 4'd0 || co_o[i] !== 1'b0) begin
                errors++; $display("FAIL re_over_ld[%0d]: got c=%0d co=%b want c=0 co=0", i, c_o[i], co_o[i]);
            end
        end
        re = 1'b0; ld = 1'b0;
    endtask

    task automatic test_back_to_back();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (c_o[3] !== 4'(k % 2)) begin errors++; $display("FAIL m2_c %0d: got %0d want %0d", k, c_o[3], k % 2); end
            checks++;
            if (co_o[3] !== (k % 2 == 0)) begin errors++; $display("FAIL m2_co %0d: got %b want %b", k, co_o[3], k % 2 == 0); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            re = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            d  = 4'($urandom);
            tick();
            for (int i = 0; i < 4; i++) begin
                logic etc;
                etc = up ? (mc[i] == m_mod[i] - 1) : (mc[i] == 0);
                checks++;
                if (c_o[i] !== 4'(mc[i])) begin errors++; $display("FAIL rand_c[%0d] cyc %0d: got %0d want %0d", i, n, c_o[i], mc[i]); end
                checks++;
                if (co_o[i] !== mco[i]) begin errors++; $display("FAIL rand_co[%0d] cyc %0d: got %b want %b", i, n, co_o[i], mco[i]); end
                checks++;
                if (tc_o[i] !== etc) begin errors++; $display("FAIL rand_tc[%0d] cyc %0d: got %b want %b", i, n, tc_o[i], etc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_saturate();
        test_prescale();
        test_load_priority();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/b_syn_updown.md
B_SYN_UPDOWN -- requirements
Module: b_syn_updown

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits.
REQ-002 Parameter MODULUS, default 16, SHALL set the count range to 0..MODULUS-1; the legal range is 2 <= MODULUS <= 2^WIDTH.
REQ-003 Parameter PRESCALE, default 1, SHALL set the number of enabled cycles per count step; PRESCALE >= 1.
REQ-004 Parameter SAT, default 0, SHALL select the end-of-range behaviour: 0 = wrap, 1 = saturate.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 re  input  1  SHALL be the reset, synchronous and active-high.
REQ-007 en  input  1  SHALL be the count enable.
REQ-008 up  input  1  SHALL be the direction: 1 = up, 0 = down.
REQ-009 ld  input  1  SHALL be the synchronous load strobe.
REQ-010 d  input  WIDTH  SHALL be the load value.
REQ-011 c  output  WIDTH  SHALL be the registered count.
REQ-012 tc  output  1  SHALL be the combinational terminal-count flag.
REQ-013 co  output  1  SHALL be the registered wrap pulse.

Function
REQ-014 Priority per rising edge SHALL be: re > ld > step; lower-priority actions are ignored in that cycle.
REQ-015 Internal prescale counter p (0..PRESCALE-1):
- en=1, p<PRESCALE-1: p increments, no step.
- en=1, p=PRESCALE-1: p clears to 0 and a step occurs.
- en=0: p and c hold.
REQ-016 With PRESCALE=1, every en=1 cycle SHALL be a step (p stays 0).
REQ-017 Step with up=1:
- c<MODULUS-1: c+1.
- c=MODULUS-1, SAT=0: c becomes 0.
- c=MODULUS-1, SAT=1: c holds.
REQ-018 Step with up=0:
- c>0: c-1.
- c=0, SAT=0: c becomes MODULUS-1.
- c=0, SAT=1: c holds.
REQ-019 co SHALL be 1 for exactly the one cycle after a step that wrapped c (REQ-017/018, SAT=0); otherwise 0, including saturating holds, loads and resets.
REQ-020 Back-to-back wraps, e.g. MODULUS=2 counting continuously, SHALL produce co on every qualifying cycle with no merging.
REQ-021 tc SHALL be (up=1 and c=MODULUS-1) or (up=0 and c=0); it follows up combinationally, regardless of en.
REQ-022 ld=1 SHALL load c with d when d <= MODULUS-1, else with MODULUS-1 (clamp), clear p to 0, and force co to 0 next cycle.
REQ-023 A direction change SHALL take effect at the next step and SHALL NOT alter p.
REQ-024 Arithmetic SHALL be unsigned WIDTH-bit, and c SHALL never hold a value >= MODULUS.
REQ-025 ld and en both 1 SHALL load only; counting resumes from the loaded value on the next step.

Reset
REQ-026 re=1 at a rising edge SHALL set c=0, p=0, co=0 on that edge, regardless of en/ld/up.
REQ-027 re asserted mid-prescale or mid-count SHALL discard the partial prescale progress; the first step after re falls SHALL need a full PRESCALE enabled cycles.
REQ-028 After reset with up=0, tc SHALL read 1 immediately (c=0).

Verification (WIDTH=4, MODULUS=10, PRESCALE=1, SAT=0 unless noted)
REQ-029 re=1 for 2 cycles, then en=1, up=1 for 12 cycles -> c = 0,1,...,9,0,1,2; co=1 only in the cycle c first reads 0 after 9; tc=1 while c=9.
REQ-030 Load d=7, then en=1, up=0 for 9 cycles -> c = 7,6,...,0,9,8; co=1 in the cycle after 0->9; tc=1 while c=0.
REQ-031 SAT=1: load d=8, up=1, en=1 for 4 cycles -> c = 8,9,9,9; co stays 0. Then up=0 -> c = 8,7.
REQ-032 PRESCALE=3: en=1, up=1 from reset -> c increments every 3rd cycle (0,0,0,1,1,1,2...); drop en for 2 cycles mid-prescale -> the step is delayed exactly 2 cycles.
REQ-033 Load d=15 (MODULUS=10) -> c=9. Then ld=1 and en=1 together with d=3 -> c=3 and no step that cycle. Then re=1 together with ld=1 -> c=0, co=0.
REQ-034 MODULUS=2, en=1 continuous -> c toggles 0,1,0,1; co=1 on every cycle c reads 0 after 1.
